// File: rtl/mips_mc_core.sv
// Multi-cycle MIPS subset core. An FSM steps each instruction through fetch,
// decode, execute, memory and writeback. Fetches and data accesses share one req/ready port.
module mips_mc_core #(
    parameter logic [31:0] RESET_PC        = 32'h0000_3000,
    parameter int          ADDR_W          = 32,
    parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc_dbg,
    output logic              halted
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_alu;
    logic [31:0] r_mdr;
    logic [31:0] r_gpr [32];

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_dest;
    logic [15:0] w_imm;
    logic [31:0] w_simm;
    logic        w_is_r_alu;
    logic        w_is_jr;
    logic        w_is_lw;
    logic        w_is_sw;
    logic        w_legal;

    assign w_op       = r_ir[31:26];
    assign w_rs       = r_ir[25:21];
    assign w_rt       = r_ir[20:16];
    assign w_rd       = r_ir[15:11];
    assign w_funct    = r_ir[5:0];
    assign w_imm      = r_ir[15:0];
    assign w_simm     = {{16{w_imm[15]}}, w_imm};
    assign w_is_r_alu = (w_op == OP_RTYPE) && (w_funct == FN_ADDU || w_funct == FN_SUBU);
    assign w_is_jr    = (w_op == OP_RTYPE) && (w_funct == FN_JR);
    assign w_is_lw    = (w_op == OP_LW);
    assign w_is_sw    = (w_op == OP_SW);
    assign w_dest     = (w_op == OP_RTYPE) ? w_rd : w_rt;
    assign w_legal    = w_is_r_alu || w_is_jr || w_op == OP_J || w_op == OP_JAL ||
                        w_op == OP_BEQ || w_op == OP_ORI || w_op == OP_LUI ||
                        w_is_lw || w_is_sw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_alu   <= '0;
            r_mdr   <= '0;
            for (int i = 0; i < 32; i++) r_gpr[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir    <= mem_rdata;
                        r_pc    <= r_pc + 32'd4;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a <= r_gpr[w_rs];
                    r_b <= r_gpr[w_rt];
                    if (!w_legal) r_state <= HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
                    else          r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_state <= S_FETCH;
                    case (w_op)
                        OP_RTYPE: begin
                            if (w_is_jr) begin
                                r_pc <= r_a;
                            end else begin
                                r_alu   <= (w_funct == FN_ADDU) ? r_a + r_b : r_a - r_b;
                                r_state <= S_WB;
                            end
                        end
                        OP_ORI: begin
                            r_alu   <= r_a | {16'h0000, w_imm};
                            r_state <= S_WB;
                        end
                        OP_LUI: begin
                            r_alu   <= {w_imm, 16'h0000};
                            r_state <= S_WB;
                        end
                        OP_LW, OP_SW: begin
                            r_alu   <= r_a + w_simm;
                            r_state <= S_MEM;
                        end
                        // r_pc already points past the branch, so the offset is taken from there
                        OP_BEQ: if (r_a == r_b) r_pc <= r_pc + {w_simm[29:0], 2'b00};
                        OP_J:   r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                        OP_JAL: begin
                            r_pc       <= {r_pc[31:28], r_ir[25:0], 2'b00};
                            r_gpr[31]  <= r_pc;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (w_is_sw) begin
                            r_state <= S_FETCH;
                        end else begin
                            r_mdr   <= mem_rdata;
                            r_state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (w_dest != 5'd0) r_gpr[w_dest] <= w_is_lw ? r_mdr : r_alu;
                    r_state <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Gating with rst abandons an in-flight access as soon as reset asserts,
    // while still letting the first fetch request go out in the cycle reset releases.
    assign mem_req   = rst && (r_state == S_FETCH || r_state == S_MEM);
    assign mem_we    = rst && (r_state == S_MEM) && w_is_sw;
    assign mem_addr  = (r_state == S_MEM) ? {r_alu[ADDR_W-1:2], 2'b00} : {r_pc[ADDR_W-1:2], 2'b00};
    assign mem_wdata = r_b;
    assign pc_dbg    = r_pc;
    assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_mips_mc_core.sv
// Bench for mips_mc_core: wait-state memory responder, ISA-level reference model
// that predicts every bus transaction (cycle, address, strobe, data), directed and random programs.
module tb_mips_mc_core;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          PBASE    = 3072;
  localparam logic [31:0] ILL      = 32'hFC00_0000;
  localparam logic [5:0]  OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_ORI = 6'h0d;
  localparam logic [5:0]  OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0]  FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_JR = 6'h08;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic mem_req, mem_we, mem_ready, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;

  logic [31:0] mem     [4096];
  logic [31:0] img     [4096];
  logic [31:0] ref_mem [4096];
  logic [96:0] exp_q[$];
  logic [31:0] cyc;
  logic [31:0] halt_cyc;
  int wait_n;
  int wcnt;
  int n_checks;
  int n_errors;

  // ---------------- clock / reset / environment ----------------
  always #5 clk = ~clk;

  mips_mc_core dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc_dbg(pc_dbg), .halted(halted)
  );

  assign mem_rdata = mem[mem_addr[13:2]];
  assign mem_ready = mem_req && (wcnt >= wait_n);

  always @(posedge clk) begin
    if (!rst || !mem_req || mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (!rst) cyc <= '0;
    else cyc <= cyc + 32'd1;
    if (!rst) mem <= img;
    else if (mem_req && mem_ready && mem_we) mem[mem_addr[13:2]] <= mem_wdata;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [31:0] target);
    return {op, target[27:2]};
  endfunction

  task automatic clear_img();
    for (int i = 0; i < 4096; i++) img[i] = 32'h0;
  endtask

  task automatic put(input int idx, input logic [31:0] word);
    img[PBASE + idx] = word;
  endtask

  // ---------------- reference model ----------------
  // Interprets the program at ISA level and predicts each bus transaction with
  // its cycle from the per-instruction latency table plus wait cycles per access.
  task automatic ref_run(input int w, output logic [31:0] hcyc);
    logic [31:0] rf [32];
    logic [31:0] pc, ir, a, b, ea, simm;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    int t;
    bit done;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    pc = RESET_PC; t = 0; done = 1'b0; hcyc = '1;
    exp_q.delete();
    for (int n = 0; n < 400 && !done; n++) begin
      exp_q.push_back({32'(t + w), 1'b0, pc, 32'h0});
      ir = ref_mem[pc[13:2]];
      t = t + w + 1;
      pc = pc + 32'd4;
      op = ir[31:26]; rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
      fn = ir[5:0]; imm = ir[15:0]; simm = {{16{imm[15]}}, imm};
      a = rf[rs]; b = rf[rt];
      if (op == 6'h00 && fn == FN_ADDU) begin
        if (rd != 0) rf[rd] = a + b;
        t += 3;
      end else if (op == 6'h00 && fn == FN_SUBU) begin
        if (rd != 0) rf[rd] = a - b;
        t += 3;
      end else if (op == 6'h00 && fn == FN_JR) begin
        pc = a; t += 2;
      end else if (op == OP_ORI) begin
        if (rt != 0) rf[rt] = a | {16'h0, imm};
        t += 3;
      end else if (op == OP_LUI) begin
        if (rt != 0) rf[rt] = {imm, 16'h0};
        t += 3;
      end else if (op == OP_LW) begin
        ea = a + simm;
        exp_q.push_back({32'(t + 2 + w), 1'b0, ea[31:2], 2'b00, 32'h0});
        if (rt != 0) rf[rt] = ref_mem[ea[13:2]];
        t += 4 + w;
      end else if (op == OP_SW) begin
        ea = a + simm;
        exp_q.push_back({32'(t + 2 + w), 1'b1, ea[31:2], 2'b00, b});
        ref_mem[ea[13:2]] = b;
        t += 3 + w;
      end else if (op == OP_BEQ) begin
        if (a == b) pc = pc + (simm << 2);
        t += 2;
      end else if (op == OP_J || op == OP_JAL) begin
        if (op == OP_JAL) rf[31] = pc;
        pc = {pc[31:28], ir[25:0], 2'b00};
        t += 2;
      end else begin
        hcyc = 32'(t + 1);
        done = 1'b1;
      end
    end
  endtask

  // ---------------- scoreboard / driver tasks ----------------
  task automatic monitor_step();
    logic [96:0] e;
    check("halted", 32'(halted), 32'(cyc >= halt_cyc));
    if (mem_req) begin
      if (exp_q.size() == 0) begin
        check("unexpected_req", 32'(mem_req), 32'd0);
      end else begin
        e = exp_q[0];
        check("addr", mem_addr, e[63:32]);
        check("we", 32'(mem_we), 32'(e[64]));
        if (e[64]) check("wdata", mem_wdata, e[31:0]);
        if (mem_ready) begin
          check("cycle", cyc, e[96:65]);
          void'(exp_q.pop_front());
        end
      end
    end
  endtask

  task automatic start(input int w);
    wait_n = w;
    repeat (2) @(posedge clk);
    ref_mem = img;
    ref_run(w, halt_cyc);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("start_pc", pc_dbg, RESET_PC);
    check("start_req", 32'(mem_req), 32'd1);
    monitor_step();
  endtask

  task automatic run_until_halt(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || cyc <= halt_cyc) && n < budget) begin
      @(negedge clk);
      monitor_step();
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (20) begin
      @(negedge clk);
      monitor_step();
      check("halt_req", 32'(mem_req), 32'd0);
    end
  endtask

  // Called at a negedge; asserts reset between edges and checks the asynchronous effect.
  task automatic stop();
    #2 rst = 1'b0;
    #1;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_pc", pc_dbg, RESET_PC);
    check("rst_halted", 32'(halted), 32'd0);
    exp_q.delete();
    halt_cyc = '1;
  endtask

  task automatic gen_random(input int n);
    clear_img();
    for (int i = 0; i < n; i++) begin
      int k;
      logic [4:0] ra, rb, rc;
      k  = $urandom_range(0, 6);
      ra = 5'($urandom_range(0, 7));
      rb = 5'($urandom_range(0, 7));
      rc = 5'($urandom_range(0, 7));
      case (k)
        0: put(i, enc_r(ra, rb, rc, FN_ADDU));
        1: put(i, enc_r(ra, rb, rc, FN_SUBU));
        2: put(i, enc_i(OP_ORI, ra, rb, 16'($urandom)));
        3: put(i, enc_i(OP_LUI, 5'd0, rb, 16'($urandom)));
        4: put(i, enc_i(OP_LW, 5'd0, rb, 16'($urandom_range(0, 31) * 4)));
        5: put(i, enc_i(OP_SW, 5'd0, rb, 16'($urandom_range(0, 31) * 4)));
        default: put(i, enc_i(OP_BEQ, ra, rb, 16'($urandom_range(0, 3))));
      endcase
    end
    for (int i = n; i < n + 4; i++) put(i, ILL);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks = 0;
    n_errors = 0;
    wait_n   = 0;
    halt_cyc = '1;
    clear_img();
    repeat (2) @(negedge clk);
    check("reset_req", 32'(mem_req), 32'd0);
    check("reset_pc", pc_dbg, RESET_PC);
    check("reset_halted", 32'(halted), 32'd0);

    // ALU ops, zero-wait memory; fourth fetch lands at cycle 12
    clear_img();
    put(0, enc_i(OP_ORI, 5'd0, 5'd1, 16'h1234));
    put(1, enc_i(OP_LUI, 5'd0, 5'd2, 16'hABCD));
    put(2, enc_r(5'd1, 5'd2, 5'd3, FN_ADDU));
    put(3, enc_r(5'd1, 5'd1, 5'd4, FN_SUBU));
    put(4, enc_r(5'd1, 5'd1, 5'd0, FN_ADDU));
    put(5, enc_i(OP_SW, 5'd0, 5'd3, 16'h0000));
    put(6, enc_i(OP_SW, 5'd0, 5'd4, 16'h0004));
    put(7, enc_i(OP_SW, 5'd0, 5'd0, 16'h0010));
    put(8, ILL);
    start(0);
    run_until_halt(500);
    check("p1_r3", mem[0], 32'hABCD_1234);
    check("p1_r4", mem[1], 32'h0000_0000);
    check("p1_r0", mem[4], 32'h0000_0000);
    stop();

    // three wait cycles on every access; store then load back
    clear_img();
    put(0, enc_i(OP_ORI, 5'd0, 5'd1, 16'h1234));
    put(1, enc_i(OP_LUI, 5'd0, 5'd2, 16'hABCD));
    put(2, enc_r(5'd1, 5'd2, 5'd3, FN_ADDU));
    put(3, enc_i(OP_SW, 5'd0, 5'd3, 16'h0008));
    put(4, enc_i(OP_LW, 5'd0, 5'd5, 16'h0008));
    put(5, enc_i(OP_SW, 5'd0, 5'd5, 16'h000C));
    put(6, ILL);
    start(3);
    run_until_halt(800);
    check("p2_sw", mem[2], 32'hABCD_1234);
    check("p2_r5", mem[3], 32'hABCD_1234);
    stop();

    // control flow: beq back to 0x300C then falls through, jal/jr round trip
    clear_img();
    put(0,  enc_i(OP_ORI, 5'd0, 5'd1, 16'h0001));
    put(1,  enc_i(OP_ORI, 5'd0, 5'd2, 16'h0001));
    put(2,  enc_j(OP_J, 32'h0000_3010));
    put(3,  enc_r(5'd2, 5'd1, 5'd2, FN_ADDU));
    put(4,  enc_i(OP_BEQ, 5'd1, 5'd2, 16'hFFFE));
    put(5,  enc_r(5'd1, 5'd1, 5'd0, FN_ADDU));
    put(6,  enc_i(OP_SW, 5'd0, 5'd0, 16'h0040));
    put(7,  enc_i(OP_ORI, 5'd0, 5'd4, 16'h0055));
    put(8,  enc_j(OP_JAL, 32'h0000_3030));
    put(9,  enc_i(OP_SW, 5'd0, 5'd31, 16'h0044));
    put(10, ILL);
    put(12, enc_r(5'd31, 5'd0, 5'd0, FN_JR));
    start(1);
    run_until_halt(800);
    check("p3_r0", mem[16], 32'h0000_0000);
    check("p3_r31", mem[17], 32'h0000_3024);
    stop();

    // random straight-line programs with forward branches and varying wait states
    for (int r = 0; r < 6; r++) begin
      gen_random(24);
      start($urandom_range(0, 2));
      run_until_halt(3000);
      stop();
    end

    // reset in the middle of a random program, preferably mid-access, then dump all GPRs
    gen_random(30);
    start(2);
    repeat (40) begin
      @(negedge clk);
      monitor_step();
    end
    for (int i = 0; i < 50; i++) begin
      if (mem_req) break;
      @(negedge clk);
      monitor_step();
    end
    stop();
    clear_img();
    for (int i = 1; i < 32; i++) put(i - 1, enc_i(OP_SW, 5'd0, 5'(i), 16'(128 + 4 * i)));
    put(31, ILL);
    start(0);
    run_until_halt(1000);
    stop();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
